// File: rtl/display_scan_if.sv
// Bundle of the scan controller's data-side signals: the master drives the
// value/controls, the slave (display_scan) returns the digit and anode drives.
interface display_scan_if;
    logic        en;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  anode;

    modport master (output en, output value, output blank_lz,
                    input  digit, input anode);
    modport slave  (input  en, input  value, input  blank_lz,
                    output digit, output anode);
endinterface

// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment scanner with a per-slot anti-ghosting
// guard, frame-atomic value latching and optional leading-zero blanking.
module display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    display_scan_if.slave  bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_V = PW'(GUARD);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    slot_q, slot_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    anode_q, anode_d;
    logic [3:0]    digit_q, digit_d;
    logic          wrap;

    // A nibble is a leading zero when it and every more significant nibble are zero.
    function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] s,
                                      input logic blz);
        logic z;
        case (s)
            2'd3:    z = (d[15:12] == 4'h0);
            2'd2:    z = (d[15:8]  == 8'h00);
            2'd1:    z = (d[15:4]  == 12'h000);
            default: z = 1'b0;
        endcase
        return blz & z;
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] s);
        return d[{s, 2'b00} +: 4];
    endfunction

    always_comb begin
        wrap   = (pre_q == PRE_MAX);
        pre_d  = wrap ? '0 : pre_q + 1'b1;
        slot_d = wrap ? slot_q + 2'd1 : slot_q;
        disp_d = (wrap && slot_q == 2'd3) ? bus.value : disp_q;

        // Outputs are derived from the next state so they line up with it after the edge.
        anode_d = (bus.en && pre_d >= GUARD_V) ? ~(4'b0001 << slot_d) : 4'b1111;
        digit_d = (!bus.en || lz_blank(disp_d, slot_d, bus.blank_lz))
                  ? 4'hF : nibble(disp_d, slot_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q   <= '0;
            slot_q  <= 2'd0;
            disp_q  <= 16'h0000;
            anode_q <= 4'b1111;
            digit_q <= 4'hF;
        end else begin
            pre_q   <= pre_d;
            slot_q  <= slot_d;
            disp_q  <= disp_d;
            anode_q <= anode_d;
            digit_q <= digit_d;
        end
    end

    assign bus.anode = anode_q;
    assign bus.digit = digit_q;
endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The parameter REFRESH_DIV SHALL default to 100000 and SHALL set the clock cycles per digit slot (legal range 4..2^20).
REQ-002 The parameter GUARD SHALL default to 500 and SHALL set the anti-ghosting cycles at the start of each slot during which all anodes are off (legal range 1..REFRESH_DIV-2).
REQ-003 clk input 1: the single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n input 1: synchronous, active-low reset.
REQ-005 en input 1: display enable; when 0, all anodes are off.
REQ-006 value input 16: four BCD nibbles; [15:12] is digit 3 (most significant) and [3:0] is digit 0.
REQ-007 blank_lz input 1: when 1, leading zeros are suppressed.
REQ-008 digit output 4: nibble for the downstream seven-segment decoder; 4'hF means blank.
REQ-009 anode output 4: active-low digit enables; bit k drives digit k.

Function
REQ-010 The block SHALL keep a prescaler that counts 0..REFRESH_DIV-1 and wraps to 0.
REQ-011 The block SHALL keep a 2-bit slot index that advances only on the prescaler wrap cycle, in the order 0,1,2,3,0.
REQ-012 The block SHALL latch value into an internal 16-bit display register on every slot 3->0 transition, and only then, so that a mid-scan change of value never tears a frame.
REQ-013 A change of value SHALL first appear on digit at the next slot-0 entry; the worst-case delay is 4*REFRESH_DIV cycles.
REQ-014 anode and digit SHALL be registered and SHALL reflect the prescaler, slot and display register as they are after the same clock edge (no extra pipeline stage).
REQ-015 anode SHALL be ~(4'b0001 << slot) when en=1 and prescaler >= GUARD; otherwise it SHALL be 4'b1111.
REQ-016 digit SHALL be the display-register nibble for the current slot, unless blanking applies under REQ-017 or en=0, in which case it SHALL be 4'hF.
REQ-017 Leading-zero blanking: with blank_lz=1, nibble k (k=3..1) SHALL be blanked when it and every higher nibble equal 4'h0; nibble 0 is never blanked.
REQ-018 blank_lz SHALL be sampled live each cycle, not latched.
REQ-019 Nibbles with values 4'hA..4'hF SHALL pass through unmodified (the decoder blanks them), and they count as non-zero for REQ-017.
REQ-020 en SHALL NOT stop the prescaler or slot index; when en returns to 1, the scan resumes in whatever slot is current.
REQ-021 en falling SHALL force anode=4'b1111 and digit=4'hF on the next edge.
REQ-022 At no cycle SHALL more than one anode bit be low.

Reset
REQ-023 On any rising clk edge with rst_n=0, the block SHALL set prescaler=0, slot=0, display register=16'h0000, anode=4'b1111 and digit=4'hF.
REQ-024 Reset asserted mid-slot or mid-frame SHALL take priority over all other updates.
REQ-025 After rst_n rises, the first scan SHALL begin at slot 0 and shall show all zeros (blanked per REQ-017) until the first 3->0 transition latches value.
REQ-026 All outputs SHALL be defined (no X) from the first post-reset edge.

Verification (REFRESH_DIV=8, GUARD=2 unless stated)
REQ-027 Reset/basic scan: hold rst_n=0 for 3 cycles, then en=1, value=16'h1234, blank_lz=0 -> during reset anode=1111 and digit=F; the first frame shows 0,0,0,0; from the second frame slot 0 shows digit=4 with anode=1110 on prescaler 2..7, then digit 3 with anode 1101, 2 with 1011, 1 with 0111.
REQ-028 Guard/ghosting: monitor every cycle -> anode=1111 on prescaler 0..1 of each slot, and REQ-022 holds throughout 10 frames.
REQ-029 Leading zeros: value=16'h0050 with blank_lz=1 -> digits 3..0 show F,F,5,0; value=16'h0000 -> F,F,F,0; value=16'h0A00 -> F,A,0,0; with blank_lz=0 and value 16'h0050 -> 0,0,5,0.
REQ-030 Tear-free latch: change value from 16'h1111 to 16'h2222 while in slot 1 -> slots 2 and 3 of that frame still show 1, and the next frame shows 2 in all slots.
REQ-031 Enable/reset mid-operation: drop en during slot 2 -> anode=1111 and digit=F on the next edge while slot continues to advance; raise en -> display resumes in the current slot; assert rst_n=0 at prescaler 5 of slot 3 -> the next edge gives prescaler=0, slot=0, anode=1111, digit=F, and the register is cleared.
